// File: rtl/ahb_lite_master_if.sv
// Command/response handshake plus AHB-Lite initiator signals for ahb_lite_master.
// master: the ahb_lite_master side; slave: the command source, response sink and bus slave.
interface ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [1:0]  cmd_size;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single non-pipelined AHB-Lite master fed by a command/response handshake.
// Define AHB_MASTER_TIMEOUT_EN to abort a transfer after 255 consecutive HREADY=0 cycles.
module ahb_lite_master (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_lite_master_if.master bus
);
  // state | meaning
  // IDLE  | cmd_ready high, waiting for a command
  // ADDR  | NONSEQ address phase, held while HREADY low
  // DATA  | data phase, write data driven / read data captured on HREADY
  // RESP  | rsp_valid high until rsp_ready
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state;
  logic        illegal;
  logic        to_hit;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  assign bus.HBURST = 3'b000;
  assign bus.HPROT  = 4'b0011;

  always_comb begin
    illegal = 1'b0;
    case (bus.cmd_size)
      2'd1:    illegal = bus.cmd_addr[0];
      2'd2:    illegal = |bus.cmd_addr[1:0];
      2'd3:    illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  always_comb begin
    wdata_rep = bus.cmd_wdata;
    case (bus.cmd_size)
      2'd0:    wdata_rep = {4{bus.cmd_wdata[7:0]}};
      2'd1:    wdata_rep = {2{bus.cmd_wdata[15:0]}};
      default: wdata_rep = bus.cmd_wdata;
    endcase
  end

  // Lane select uses the registered HADDR/HSIZE of the transfer in flight.
  always_comb begin
    rdata_ext = bus.HRDATA;
    case (bus.HSIZE[1:0])
      2'd0:    rdata_ext = {24'd0, bus.HRDATA[{bus.HADDR[1:0], 3'b000} +: 8]};
      2'd1:    rdata_ext = {16'd0, bus.HRDATA[{bus.HADDR[1], 4'b0000} +: 16]};
      default: rdata_ext = bus.HRDATA;
    endcase
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Fires on the 255th consecutive stalled edge.
  assign to_hit = !bus.HREADY && (wait_cnt == 8'd254);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if ((state == ADDR || state == DATA) && !bus.HREADY && !to_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b0;
      bus.HTRANS    <= HTRANS_IDLE;
      bus.HADDR     <= '0;
      bus.HWRITE    <= 1'b0;
      bus.HSIZE     <= '0;
      bus.HWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (illegal) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state      <= ADDR;
              bus.HTRANS <= HTRANS_NONSEQ;
              bus.HADDR  <= bus.cmd_addr;
              bus.HWRITE <= bus.cmd_write;
              bus.HSIZE  <= {1'b0, bus.cmd_size};
              bus.HWDATA <= bus.cmd_write ? wdata_rep : '0;
            end
          end
        end
        ADDR: begin
          if (to_hit) begin
            state         <= RESP;
            bus.HTRANS    <= HTRANS_IDLE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else if (bus.HREADY) begin
            state      <= DATA;
            bus.HTRANS <= HTRANS_IDLE;
          end
        end
        DATA: begin
          if (to_hit) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else if (bus.HREADY) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.HWRITE ? 32'd0 : rdata_ext;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master; inputs change and outputs are sampled on the falling edge.
module tb_ahb_lite_master;
  logic HCLK;
  logic HRESETn;
  int   n_tests;
  int   n_fail;

  ahb_lite_master_if bus ();

  ahb_lite_master dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic [31:0] hr;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t lanes[6];

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_size  = s;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); end
    n_tests++; if (bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %b want 00", bus.HTRANS); end
    n_tests++; if (bus.HADDR !== 32'd0) begin n_fail++; $display("FAIL reset_haddr got %h want 0", bus.HADDR); end
    n_tests++; if (bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'd0 || bus.HWDATA !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus got hwrite=%b hsize=%0d hwdata=%h want 0", bus.HWRITE, bus.HSIZE, bus.HWDATA); end
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp got valid=%b rdata=%h err=%b want 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    n_tests++; if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011) begin
      n_fail++; $display("FAIL const_hburst_hprot got %b/%b want 000/0011", bus.HBURST, bus.HPROT); end
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_word_write();
    bus.HREADY = 1'b1;
    bus.rsp_ready = 1'b0;
    drive_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h10 || bus.HSIZE !== 3'd2 || bus.HWRITE !== 1'b1) begin
      n_fail++; $display("FAIL ww_addr_phase got htrans=%b haddr=%h hsize=%0d hwrite=%b want 10/10/2/1", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE); end
    n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ww_cmd_ready_busy got %b want 0", bus.cmd_ready); end
    @(negedge HCLK);
    n_tests++; if (bus.HTRANS !== 2'b00 || bus.HWDATA !== 32'hDEAD_BEEF || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ww_data_phase got htrans=%b hwdata=%h rsp_valid=%b want 00/deadbeef/0", bus.HTRANS, bus.HWDATA, bus.rsp_valid); end
    @(negedge HCLK);
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.HTRANS !== 2'b00) begin
      n_fail++; $display("FAIL ww_resp got valid=%b err=%b rdata=%h htrans=%b want 1/0/0/00", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.HTRANS); end
    bus.rsp_ready = 1'b1;
    @(negedge HCLK);
    bus.rsp_ready = 1'b0;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL ww_handshake got rsp_valid=%b cmd_ready=%b want 0/1", bus.rsp_valid, bus.cmd_ready); end
  endtask

  task automatic test_byte_read_wait();
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hAABB_CCDD;
    drive_cmd(1'b0, 32'h0000_0013, 32'h0, 2'd0);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h13 || bus.HSIZE !== 3'd0 || bus.HWRITE !== 1'b0) begin
      n_fail++; $display("FAIL br_addr_phase got htrans=%b haddr=%h hsize=%0d hwrite=%b want 10/13/0/0", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE); end
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    n_tests++; if (bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL br_data_htrans got %b want 00", bus.HTRANS); end
    @(negedge HCLK);
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.HADDR !== 32'h13) begin
      n_fail++; $display("FAIL br_wait1 got rsp_valid=%b haddr=%h want 0/13", bus.rsp_valid, bus.HADDR); end
    @(negedge HCLK);
    bus.HREADY = 1'b1;
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL br_wait2 got rsp_valid=%b want 0", bus.rsp_valid); end
    @(negedge HCLK);
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_00AA || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL br_resp got valid=%b rdata=%h err=%b want 1/000000aa/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    bus.rsp_ready = 1'b1;
    @(negedge HCLK);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_lanes();
    lanes[0] = '{1'b1, 32'h0000_0020, 32'h1234_565A, 2'd0, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 32'h0};
    lanes[1] = '{1'b1, 32'h0000_0022, 32'h0000_BEEF, 2'd1, 32'hFFFF_FFFF, 32'hBEEF_BEEF, 32'h0};
    lanes[2] = '{1'b0, 32'h0000_0041, 32'h0,         2'd0, 32'h1122_3344, 32'h0,         32'h0000_0033};
    lanes[3] = '{1'b0, 32'h0000_0042, 32'h0,         2'd1, 32'h1122_3344, 32'h0,         32'h0000_1122};
    lanes[4] = '{1'b0, 32'h0000_0040, 32'h0,         2'd1, 32'h1122_3344, 32'h0,         32'h0000_3344};
    lanes[5] = '{1'b0, 32'h0000_0044, 32'h0,         2'd2, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D};
    bus.HREADY = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.HRDATA = lanes[i].hr;
      drive_cmd(lanes[i].w, lanes[i].a, lanes[i].d, lanes[i].s);
      @(negedge HCLK);
      bus.cmd_valid = 1'b0;
      n_tests++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== lanes[i].a || bus.HSIZE !== {1'b0, lanes[i].s} || bus.HWRITE !== lanes[i].w) begin
        n_fail++; $display("FAIL lane%0d_addr got htrans=%b haddr=%h hsize=%0d want 10/%h/%0d", i, bus.HTRANS, bus.HADDR, bus.HSIZE, lanes[i].a, lanes[i].s); end
      @(negedge HCLK);
      if (lanes[i].w) begin
        n_tests++; if (bus.HWDATA !== lanes[i].exp_wd) begin
          n_fail++; $display("FAIL lane%0d_hwdata got %h want %h", i, bus.HWDATA, lanes[i].exp_wd); end
      end
      n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lane%0d_early_rsp got %b want 0", i, bus.rsp_valid); end
      @(negedge HCLK);
      n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== lanes[i].exp_rd || bus.rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL lane%0d_resp got valid=%b rdata=%h err=%b want 1/%h/0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, lanes[i].exp_rd); end
      @(negedge HCLK);
      n_tests++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL lane%0d_done got rsp_valid=%b cmd_ready=%b want 0/1", i, bus.rsp_valid, bus.cmd_ready); end
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    logic        wr    [3];
    addrs[0] = 32'h0000_0001; sizes[0] = 2'd1; wr[0] = 1'b1;
    addrs[1] = 32'h0000_0000; sizes[1] = 2'd3; wr[1] = 1'b1;
    addrs[2] = 32'h0000_0006; sizes[2] = 2'd2; wr[2] = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(wr[i], addrs[i], 32'h1234_5678, sizes[i]);
      @(negedge HCLK);
      bus.cmd_valid = 1'b0;
      n_tests++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'd0 || bus.cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d got htrans=%b valid=%b err=%b rdata=%h cmd_ready=%b want 00/1/1/0/0",
                           i, bus.HTRANS, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.cmd_ready); end
      bus.rsp_ready = 1'b1;
      @(negedge HCLK);
      bus.rsp_ready = 1'b0;
      n_tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.HTRANS !== 2'b00) begin
        n_fail++; $display("FAIL illegal%0d_done got valid=%b err=%b htrans=%b want 0/0/00", i, bus.rsp_valid, bus.rsp_err, bus.HTRANS); end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h0BAD_F00D;
    bus.rsp_ready = 1'b0;
    drive_cmd(1'b0, 32'h0000_0008, 32'h0, 2'd2);
    repeat (3) @(negedge HCLK);
    drive_cmd(1'b1, 32'h0000_000C, 32'h0000_0001, 2'd2);
    bus.HRDATA = 32'h0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BAD_F00D || bus.cmd_ready !== 1'b0 || bus.HTRANS !== 2'b00) bad++;
      @(negedge HCLK);
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL bp_before_hs got valid=%b rdata=%h want 1/0badf00d", bus.rsp_valid, bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
    @(negedge HCLK);
    bus.rsp_ready = 1'b0;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.HTRANS !== 2'b00) begin
      n_fail++; $display("FAIL bp_after_hs got valid=%b cmd_ready=%b htrans=%b want 0/1/00", bus.rsp_valid, bus.cmd_ready, bus.HTRANS); end
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h0C || bus.HWRITE !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_cmd got htrans=%b haddr=%h hwrite=%b cmd_ready=%b want 10/0c/1/0", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.cmd_ready); end
    repeat (2) @(negedge HCLK);
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL bp_next_resp got valid=%b err=%b rdata=%h want 1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
    @(negedge HCLK);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h7777_7777;
    drive_cmd(1'b0, 32'h0000_0030, 32'h0, 2'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    @(negedge HCLK);
    n_tests++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.HADDR !== 32'h30) begin
      n_fail++; $display("FAIL rm_in_data got htrans=%b valid=%b haddr=%h want 00/0/30", bus.HTRANS, bus.rsp_valid, bus.HADDR); end
    #2 HRESETn = 1'b0;
    #1;
    n_tests++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.HADDR !== 32'd0 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL rm_async got htrans=%b valid=%b haddr=%h cmd_ready=%b want 00/0/0/0", bus.HTRANS, bus.rsp_valid, bus.HADDR, bus.cmd_ready); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.HREADY = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge HCLK);
      if (bus.rsp_valid !== 1'b0 || bus.HTRANS !== 2'b00) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rm_no_resp got %0d bad cycles want 0", bad); end
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_timeout();
    int waits;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h9999_9999;
    bus.rsp_ready = 1'b0;
    drive_cmd(1'b0, 32'h0000_0050, 32'h0, 2'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    bus.HREADY = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
    waits = 0;
    while (bus.rsp_valid !== 1'b1 && waits < 300) begin
      waits++;
      @(negedge HCLK);
    end
    n_tests++; if (waits !== 255) begin n_fail++; $display("FAIL to_wait_cycles got %0d want 255", waits); end
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'd0 || bus.HTRANS !== 2'b00) begin
      n_fail++; $display("FAIL to_resp got valid=%b err=%b rdata=%h htrans=%b want 1/1/0/00", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.HTRANS); end
`else
    waits = 0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.rsp_valid !== 1'b0) waits++;
      @(negedge HCLK);
    end
    n_tests++; if (waits !== 0) begin n_fail++; $display("FAIL nto_no_resp got %0d response cycles want 0", waits); end
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h9999_9999) begin
      n_fail++; $display("FAIL nto_late_resp got valid=%b err=%b rdata=%h want 1/0/99999999", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
`endif
    bus.HREADY = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge HCLK);
    bus.rsp_ready = 1'b0;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL to_done got valid=%b cmd_ready=%b want 0/1", bus.rsp_valid, bus.cmd_ready); end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    HRESETn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_size = 2'd0;
    bus.rsp_ready = 1'b0;
    bus.HRDATA = 32'd0;
    bus.HREADY = 1'b1;
    test_reset();
    test_word_write();
    test_byte_read_wait();
    test_lanes();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have port HCLK, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port HRESETn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1; cmd_addr in 32; cmd_wdata in 32; cmd_size in 2 (0=byte, 1=half, 2=word, 3=illegal).
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32; rsp_err out 1.
REQ-005 SHALL have AHB-Lite initiator ports: HADDR out 32; HWRITE out 1; HTRANS out 2; HSIZE out 3; HBURST out 3; HPROT out 4; HWDATA out 32; HRDATA in 32; HREADY in 1.

Function
REQ-006 SHALL implement FSM IDLE, ADDR, DATA, RESP; single non-pipelined transfers only.
REQ-007 IDLE: cmd_ready=1 in IDLE only; on cmd_valid&&cmd_ready register command; if legal go ADDR, else go RESP with rsp_err=1 and no bus transfer.
REQ-008 Illegal = cmd_size==3, or half with cmd_addr[0]=1, or word with cmd_addr[1:0]!=0.
REQ-009 ADDR: HTRANS=2'b10 (NONSEQ), HADDR/HWRITE/HSIZE={0,cmd_size} from registered command; all held stable while HREADY=0; advance to DATA on edge with HREADY=1.
REQ-010 DATA: HTRANS=2'b00; HWDATA valid (writes); on edge with HREADY=1 capture read data, go RESP.
REQ-011 HWDATA lane replication: byte -> wdata[7:0] x4; half -> wdata[15:0] x2; word -> wdata.
REQ-012 Read extraction: byte lane HADDR[1:0], half lane HADDR[1], zero-extended to 32 bits into rsp_rdata; writes return rsp_rdata=0.
REQ-013 RESP: rsp_valid=1, rsp_rdata/rsp_err held until rsp_valid&&rsp_ready, then IDLE; no new command accepted during RESP.
REQ-014 Latency, zero-wait slave: accept at edge N -> ADDR cycle N+1 -> DATA N+2 -> rsp_valid from N+3; each slave wait state adds one cycle.
REQ-015 HTRANS SHALL be 2'b00 in every state except ADDR; HBURST=3'b000, HPROT=4'b0011 constant.
REQ-016 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-017 HRESETn low SHALL asynchronously force state IDLE, HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout count=0.
REQ-018 cmd_ready SHALL be 0 while HRESETn low and 1 from first edge after deassertion.
REQ-019 Reset mid-transfer SHALL drop the in-flight command with no response.

Configuration
REQ-020 Macro AHB_MASTER_TIMEOUT_EN defined: 8-bit counter counts consecutive HREADY=0 cycles in ADDR or DATA, clears on HREADY=1 or state change; at count 255 FSM SHALL go RESP with rsp_err=1, rsp_rdata=0, HTRANS=0.
REQ-021 Macro undefined: no counter; FSM waits indefinitely for HREADY; rsp_err set only by REQ-008.

Verification
REQ-022 Word write 0x0000_0010<-0xDEADBEEF, HREADY=1 -> one NONSEQ cycle HSIZE=2, HWDATA=0xDEADBEEF next cycle, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-023 Byte read 0x0000_0013, slave HRDATA=0xAABBCCDD with 2 wait states -> HADDR held 1 cycle, rsp_rdata=0x0000_00AA, rsp_valid 5 cycles after accept.
REQ-024 Half write addr 0x0000_0001 -> no NONSEQ issued, rsp_valid next cycle, rsp_err=1; cmd_size=3 -> same.
REQ-025 rsp_ready held low 4 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; new cmd accepted cycle after handshake.
REQ-026 HRESETn pulsed low during DATA with HREADY=0 -> HTRANS=0, rsp_valid=0 immediately; no response after release.
REQ-027 With AHB_MASTER_TIMEOUT_EN, HREADY stuck 0 in DATA -> rsp_valid, rsp_err=1 after 255 wait cycles; without macro, no response after 1000 cycles.
